// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO with occupancy count, synchronous flush and
// optional sticky overflow/underflow flags. Read data is registered (one-cycle
// read latency, not first-word-fall-through). Strobes are active-low.
//
// Optional feature macro: SYNC_FIFO_ERR_EN
//   defined   -> overflow/underflow are sticky error registers
//   undefined -> overflow/underflow are tied to 0 (ports still present)
//
// Parameters:
//   WIDTH     data word width (>=1)
//   DEPTH     number of entries (power of two, >=4)
//   AF_LEVEL  almost_full  when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous reset, active-low
//   clr          synchronous flush, active-high (priority over read/write)
//   data_in      write data
//   write_n      write request, active-low
//   read_n       read request, active-low
//   data_out     registered read data
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        occupancy 0..DEPTH ($clog2(DEPTH)+1 bits)
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       write_n,
    input  logic                       read_n,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] dout_q,   dout_d;

    logic wr_acc;
    logic rd_acc;

    // Flags decode the count directly.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign data_out     = dout_q;

    // Full/empty gating alone resolves simultaneous requests at the extremes:
    // at empty only the write goes through, at full only the read.
    assign wr_acc = !write_n && !full;
    assign rd_acc = !read_n  && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (clr) begin
            // Flush keeps data_out and the memory contents untouched.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                dout_d   = mem_q[rd_ptr_q];
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CW'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!clr && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // A request against full/empty flags an error even when the other
    // direction of a simultaneous request is accepted.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            if (!write_n && full) begin
                ovf_d = 1'b1;
            end
            if (!read_n && empty) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
